fetch_ctrl: RTL

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: walks a small program in a combinational
// instruction memory and buffers {pc, instr} pairs in a DEPTH-entry queue.
module fetch_ctrl #(
    parameter int PROG_WORDS = 7,
    parameter int DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] pc,
    input  logic [31:0] imem_instr,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        out_ready,
    output logic        halted,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    localparam int                PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0]       LAST_PC  = 32'(4 * PROG_WORDS - 4);
    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      fifo_instr_q [DEPTH];
    logic [31:0]      fifo_pc_q    [DEPTH];

    logic pc_in_range;
    logic pop;
    logic push;
    logic flush;

    // Handshake: a queue entry transfers on any cycle where out_valid and
    // out_ready are both high; out_valid never depends on out_ready.
    assign pc_in_range = (pc_q <= LAST_PC);
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flush   = 1'b0;
        push    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_RUN: begin
                // Redirect wins over push; an out-of-range target falls
                // through to HALT on the following cycle with nothing queued.
                if (redirect_valid) begin
                    flush = 1'b1;
                    pc_d  = {redirect_pc[31:2], 2'b00};
                end else if (pc_in_range) begin
                    if ((count_q < CNT_FULL) || pop) begin
                        push = 1'b1;
                        pc_d = pc_q + 32'd4;
                    end
                end else if (!out_valid) begin
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                if (redirect_valid) begin
                    state_d = S_RUN;
                    flush   = 1'b1;
                    pc_d    = {redirect_pc[31:2], 2'b00};
                end else if (start) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Payload storage needs no reset: it is only visible through out_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr_q[wr_ptr_q] <= imem_instr;
            fifo_pc_q[wr_ptr_q]    <= pc_q;
        end
    end

    assign pc        = pc_q;
    assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q] : '0;
    assign halted    = (state_q == S_HALT);
    assign busy      = (state_q == S_RUN);
    assign dbg_state = state_q;

endmodule
